// File: rtl/unified_buffer_burst.sv
// unified_buffer_burst: single-port word buffer shared by a byte-lane host
// port and a full-word, multi-lane burst compute port. An internal FSM
// arbitrates (compute wins), sequences bursts and pulses done/error.
// Optional feature macro: UB_BOUNDS_CHECK_EN -- when defined, bursts running
// past the end of the buffer are rejected with an error pulse instead of
// wrapping the address back to 0.
module unified_buffer_burst #(
    parameter int BUFFER_SIZE        = 1024,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int ARRAY_SIZE         = 4,
    parameter int FIFO_DATA_WIDTH    = 8,
    parameter int BUFFER_WORD_SIZE   = ARRAY_SIZE * COMPUTE_DATA_WIDTH,
    parameter int SECTIONS           = BUFFER_WORD_SIZE / FIFO_DATA_WIDTH,
    parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
    parameter int SECTION_BITS       = (SECTIONS > 1) ? $clog2(SECTIONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          host_we,
    input  logic [ADDRESS_SIZE-1:0]       host_address,
    input  logic [SECTION_BITS-1:0]       host_section,
    input  logic [FIFO_DATA_WIDTH-1:0]    host_wdata,
    output logic [FIFO_DATA_WIDTH-1:0]    host_rdata,
    output logic                          host_rvalid,
    input  logic                          cmp_start,
    input  logic                          cmp_we,
    input  logic [ADDRESS_SIZE-1:0]       cmp_base,
    input  logic [ADDRESS_SIZE:0]         cmp_len,
    output logic                          cmp_busy,
    input  logic [COMPUTE_DATA_WIDTH-1:0] compute_in [ARRAY_SIZE],
    input  logic                          compute_in_valid,
    output logic [COMPUTE_DATA_WIDTH-1:0] compute_out [ARRAY_SIZE],
    output logic                          compute_out_valid,
    output logic                          done,
    output logic                          error
);
    localparam int LEN_W = ADDRESS_SIZE + 1;
    localparam int FW    = FIFO_DATA_WIDTH;
    localparam int CW    = COMPUTE_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, RD_DRAIN} state_t;

    state_t                    state_reg;
    logic [ADDRESS_SIZE-1:0]   ptr_reg;
    logic [LEN_W-1:0]          rem_reg;
    logic                      host_rvalid_reg;
    logic                      compute_out_valid_reg;
    logic                      done_reg;
    logic                      error_reg;
    logic [SECTION_BITS-1:0]   rd_section_reg;
    logic [BUFFER_WORD_SIZE-1:0] rd_word_reg;

    logic [BUFFER_WORD_SIZE-1:0] mem [BUFFER_SIZE];

    logic                        idle;
    logic                        host_accept;
    logic                        burst_beat;
    logic                        last_word;
    logic                        reject;
    logic [ADDRESS_SIZE-1:0]     ptr_inc;
    logic [ADDRESS_SIZE-1:0]     mem_addr;
    logic [SECTIONS-1:0]         mem_wen;
    logic [BUFFER_WORD_SIZE-1:0] mem_wdata;
    logic [BUFFER_WORD_SIZE-1:0] in_word;
    logic [FW-1:0]               rd_sections [SECTIONS];

    // Host is only served in IDLE and loses to a same-cycle burst command;
    // rst gates it so nothing is accepted while the design is held in reset.
    assign idle        = (state_reg == IDLE);
    assign host_accept = idle && host_valid && !cmp_start && !rst;
    assign host_ready  = host_accept;
    assign burst_beat  = (state_reg == WR_BURST) && compute_in_valid;
    assign last_word   = (rem_reg == LEN_W'(1));
    assign ptr_inc     = (ptr_reg == ADDRESS_SIZE'(BUFFER_SIZE - 1)) ? '0 : ptr_reg + ADDRESS_SIZE'(1);

    // The single memory port follows the host in IDLE and the burst pointer otherwise.
    assign mem_addr = idle ? host_address : ptr_reg;

`ifdef UB_BOUNDS_CHECK_EN
    logic [LEN_W:0] burst_end;
    assign burst_end = {2'b00, cmp_base} + {1'b0, cmp_len};
    assign reject    = (burst_end > (LEN_W + 1)'(BUFFER_SIZE));
`else
    assign reject = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < SECTIONS; gi++) begin : g_section
            assign mem_wen[gi] = burst_beat ||
                                 (host_accept && host_we && (host_section == SECTION_BITS'(gi)));
            assign mem_wdata[gi*FW +: FW] = burst_beat ? in_word[gi*FW +: FW] : host_wdata;
            assign rd_sections[gi]        = rd_word_reg[gi*FW +: FW];
        end
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            assign in_word[gi*CW +: CW] = compute_in[gi];
            // Lanes read as zero outside a valid beat, so reset clears them at once.
            assign compute_out[gi] = compute_out_valid_reg ? rd_word_reg[gi*CW +: CW] : '0;
        end
    endgenerate

    assign host_rdata        = host_rvalid_reg ? rd_sections[rd_section_reg] : '0;
    assign host_rvalid       = host_rvalid_reg;
    assign compute_out_valid = compute_out_valid_reg;
    assign cmp_busy          = (state_reg != IDLE);
    assign done              = done_reg;
    assign error             = error_reg;

    // Buffer array: per-section write enables, registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SECTIONS; s++) begin
            if (mem_wen[s]) begin
                mem[mem_addr][s*FW +: FW] <= mem_wdata[s*FW +: FW];
            end
        end
        rd_word_reg <= mem[mem_addr];
    end

    // Arbitration and burst sequencing FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg             <= IDLE;
            ptr_reg               <= '0;
            rem_reg               <= '0;
            host_rvalid_reg       <= 1'b0;
            compute_out_valid_reg <= 1'b0;
            done_reg              <= 1'b0;
            error_reg             <= 1'b0;
            rd_section_reg        <= '0;
        end else begin
            host_rvalid_reg       <= host_accept && !host_we;
            compute_out_valid_reg <= (state_reg == RD_BURST);
            done_reg              <= 1'b0;
            error_reg             <= 1'b0;
            if (host_accept) begin
                rd_section_reg <= host_section;
            end
            case (state_reg)
                IDLE: begin
                    if (cmp_start) begin
                        if (reject) begin
                            error_reg <= 1'b1;
                        end else if (cmp_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            ptr_reg   <= cmp_base;
                            rem_reg   <= cmp_len;
                            state_reg <= cmp_we ? WR_BURST : RD_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (compute_in_valid) begin
                        ptr_reg <= ptr_inc;
                        rem_reg <= rem_reg - LEN_W'(1);
                        if (last_word) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                RD_BURST: begin
                    ptr_reg <= ptr_inc;
                    rem_reg <= rem_reg - LEN_W'(1);
                    // done is raised with the last read so it lines up with the last beat.
                    if (last_word) begin
                        state_reg <= RD_DRAIN;
                        done_reg  <= 1'b1;
                    end
                end
                RD_DRAIN: state_reg <= IDLE;
                default:  state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unified_buffer_burst.sv
// Testbench for unified_buffer_burst: host table vectors, directed burst,
// arbitration, boundary and reset sequences, then random traffic checked
// against an array model of the buffer contents.
module tb_unified_buffer_burst;
    localparam int BS = 16;
    localparam int AW = 4;
    localparam int LW = 5;
`ifdef UB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_ON = 1'b1;
`else
    localparam bit BOUNDS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       host_valid, host_ready, host_we, host_rvalid;
    logic [3:0] host_address;
    logic [0:0] host_section;
    logic [7:0] host_wdata, host_rdata;
    logic       cmp_start, cmp_we, cmp_busy;
    logic [3:0] cmp_base;
    logic [4:0] cmp_len;
    logic [3:0] compute_in [4];
    logic [3:0] compute_out [4];
    logic       compute_in_valid, compute_out_valid, done, error;

    int checks = 0;
    int failures = 0;
    logic [15:0] model_mem [BS];
    logic [15:0] bdata [32];
    logic [15:0] cap [32];

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic       sec;
        logic [7:0] wdata;
        logic [7:0] exp;
    } host_vec_t;

    unified_buffer_burst #(.BUFFER_SIZE(BS)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_address(host_address), .host_section(host_section),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .cmp_start(cmp_start), .cmp_we(cmp_we), .cmp_base(cmp_base), .cmp_len(cmp_len),
        .cmp_busy(cmp_busy), .compute_in(compute_in), .compute_in_valid(compute_in_valid),
        .compute_out(compute_out), .compute_out_valid(compute_out_valid),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required normal finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] out_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) w[i*4 +: 4] = compute_out[i];
        return w;
    endfunction

    task automatic drive_lanes(input logic [15:0] w);
        for (int i = 0; i < 4; i++) compute_in[i] = w[i*4 +: 4];
    endtask

    task automatic idle_inputs();
        host_valid = 1'b0; host_we = 1'b0; host_address = '0; host_section = '0;
        host_wdata = '0; cmp_start = 1'b0; cmp_we = 1'b0; cmp_base = '0; cmp_len = '0;
        compute_in_valid = 1'b0;
        drive_lanes(16'h0000);
    endtask

    // One host transaction issued from IDLE; returns the read byte.
    task automatic host_op(input bit we, input int addr, input int sec,
                           input logic [7:0] wd, output logic [7:0] rd);
        host_valid = 1'b1; host_we = we; host_address = AW'(addr);
        host_section = 1'(sec); host_wdata = wd;
        #1;
        check("host_ready", 32'(host_ready), 1);
        tick();
        host_valid = 1'b0;
        check("host_rvalid", 32'(host_rvalid), 32'(!we));
        rd = host_rdata;
        if (we) model_mem[addr][sec*8 +: 8] = wd;
        $display("txn host we=%0d addr=%0d sec=%0d wdata=%02h rdata=%02h", we, addr, sec, wd, rd);
    endtask

    // One burst command; write data from bdata, read data captured into cap.
    task automatic burst(input bit we, input int base, input int len, input int mask);
        bit rej;
        rej = BOUNDS_ON && (base + len > BS);
        $display("txn burst we=%0d base=%0d len=%0d reject=%0d", we, base, len, rej);
        cmp_start = 1'b1; cmp_we = we; cmp_base = AW'(base); cmp_len = LW'(len);
        tick();
        cmp_start = 1'b0;
        check("start_error", 32'(error), 32'(rej));
        check("start_valid", 32'(compute_out_valid), 0);
        if (rej || len == 0) begin
            check("start_done", 32'(done), 32'(!rej));
            check("start_busy", 32'(cmp_busy), 0);
            tick();
            check("pulse_end", 32'({error, done}), 0);
            return;
        end
        check("start_busy", 32'(cmp_busy), 1);
        check("start_done", 32'(done), 0);
        for (int i = 0; i < len; i++) begin
            if (we) begin
                if (mask[i]) begin
                    tick();
                    check("stall_busy", 32'(cmp_busy), 1);
                    check("stall_done", 32'(done), 0);
                end
                drive_lanes(bdata[i]);
                compute_in_valid = 1'b1;
                tick();
                compute_in_valid = 1'b0;
                model_mem[(base + i) % BS] = bdata[i];
                check("wr_busy", 32'(cmp_busy), 32'(i != len - 1));
                check("wr_done", 32'(done), 32'(i == len - 1));
            end else begin
                tick();
                cap[i] = out_word();
                check("rd_valid", 32'(compute_out_valid), 1);
                check("rd_data", 32'(cap[i]), 32'(model_mem[(base + i) % BS]));
                check("rd_done", 32'(done), 32'(i == len - 1));
            end
        end
        tick();
        check("end_idle", 32'({cmp_busy, compute_out_valid, done}), 0);
    endtask

    initial begin
        logic [7:0]  rd, lo, hi;
        host_vec_t   tbl [10];
        logic [15:0] exp_b [5];
        int          addr_b [5];

        // Reset state, with a host request pending that must not be accepted.
        rst = 1'b1;
        idle_inputs();
        host_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_host_ready", 32'(host_ready), 0);
        check("rst_flags", 32'({host_rvalid, cmp_busy, compute_out_valid, done, error}), 0);
        check("rst_host_rdata", 32'(host_rdata), 0);
        check("rst_compute_out", 32'(out_word()), 0);
        host_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Fill the whole buffer with a known pattern.
        for (int i = 0; i < BS; i++) bdata[i] = 16'h5500 + 16'(i);
        burst(1'b1, 0, BS, 0);

        // Table-driven host section reads and writes.
        tbl[0] = '{1'b1, 4'd5, 1'b1, 8'hAB, 8'h00};
        tbl[1] = '{1'b1, 4'd5, 1'b0, 8'hCD, 8'h00};
        tbl[2] = '{1'b0, 4'd5, 1'b1, 8'h00, 8'hAB};
        tbl[3] = '{1'b0, 4'd5, 1'b0, 8'h00, 8'hCD};
        tbl[4] = '{1'b1, 4'd6, 1'b0, 8'h12, 8'h00};
        tbl[5] = '{1'b1, 4'd6, 1'b1, 8'h34, 8'h00};
        tbl[6] = '{1'b1, 4'd6, 1'b0, 8'h56, 8'h00};
        tbl[7] = '{1'b0, 4'd6, 1'b1, 8'h00, 8'h34};
        tbl[8] = '{1'b0, 4'd6, 1'b0, 8'h00, 8'h56};
        tbl[9] = '{1'b0, 4'd7, 1'b1, 8'h00, 8'h55};
        for (int t = 0; t < 10; t++) begin
            host_op(tbl[t].we, int'(tbl[t].addr), int'(tbl[t].sec), tbl[t].wdata, rd);
            if (!tbl[t].we) check("tbl_rdata", 32'(rd), 32'(tbl[t].exp));
        end

        // Full-word read of the section-written word.
        burst(1'b0, 5, 1, 0);
        check("word_abcd", 32'(cap[0]), 32'h0000ABCD);

        // Write burst with a one-cycle gap before the second beat, then read back.
        bdata[0] = 16'h1111; bdata[1] = 16'h2222; bdata[2] = 16'h3333;
        burst(1'b1, 10, 3, 32'b010);
        burst(1'b0, 10, 3, 0);
        check("rd_beat0", 32'(cap[0]), 32'h1111);
        check("rd_beat1", 32'(cap[1]), 32'h2222);
        check("rd_beat2", 32'(cap[2]), 32'h3333);

        // Arbitration: burst wins, host held off until after done.
        host_valid = 1'b1; host_we = 1'b0; host_address = 4'd10; host_section = 1'b0;
        cmp_start = 1'b1; cmp_we = 1'b0; cmp_base = 4'd10; cmp_len = 5'd3;
        #1;
        check("arb_ready_start", 32'(host_ready), 0);
        tick();
        cmp_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("arb_host_stalled", 32'(host_ready), 0);
            check("arb_no_rvalid", 32'(host_rvalid), 0);
            check("arb_out_valid", 32'(compute_out_valid), 32'(k >= 2));
            check("arb_done", 32'(done), 32'(k == 4));
            if (k < 4) tick();
        end
        tick();
        check("arb_host_accept", 32'(host_ready), 1);
        tick();
        host_valid = 1'b0;
        check("arb_host_rvalid", 32'(host_rvalid), 1);
        check("arb_host_rdata", 32'(host_rdata), 32'h11);
        $display("txn arbitration host read after burst rdata=%02h", host_rdata);

        // Zero-length command: done pulse only, memory untouched.
        burst(1'b1, 10, 0, 0);
        host_op(1'b0, 10, 1, 8'h00, rd);
        check("len0_mem", 32'(rd), 32'h11);

        // Boundary burst across the end of the buffer.
        bdata[0] = 16'hE0E0; bdata[1] = 16'hF0F0; bdata[2] = 16'h0A0A; bdata[3] = 16'h1B1B;
        burst(1'b1, 14, 4, 0);
        addr_b = '{14, 15, 0, 1, 2};
`ifdef UB_BOUNDS_CHECK_EN
        exp_b = '{16'h550E, 16'h550F, 16'h5500, 16'h5501, 16'h5502};
`else
        exp_b = '{16'hE0E0, 16'hF0F0, 16'h0A0A, 16'h1B1B, 16'h5502};
`endif
        for (int j = 0; j < 5; j++) begin
            host_op(1'b0, addr_b[j], 0, 8'h00, lo);
            host_op(1'b0, addr_b[j], 1, 8'h00, hi);
            check("bound_word", 32'({hi, lo}), 32'(exp_b[j]));
        end

        // Reset in the middle of a 5-word read burst.
        cmp_start = 1'b1; cmp_we = 1'b0; cmp_base = 4'd3; cmp_len = 5'd5;
        tick();
        cmp_start = 1'b0;
        tick();
        check("mid_beat0", 32'(out_word()), 32'(model_mem[3]));
        tick();
        check("mid_beat1", 32'(out_word()), 32'(model_mem[4]));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_flags", 32'({compute_out_valid, done, cmp_busy, host_rvalid, error}), 0);
        check("mid_rst_out", 32'(out_word()), 0);
        check("mid_rst_rdata", 32'(host_rdata), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_quiet", 32'({compute_out_valid, done, cmp_busy}), 0);
        end
        $display("txn reset mid read burst");
        host_op(1'b0, 3, 1, 8'h00, rd);
        check("post_rst_host_hi", 32'(rd), 32'h55);
        host_op(1'b0, 3, 0, 8'h00, rd);
        check("post_rst_host_lo", 32'(rd), 32'h03);

        // Random mixed traffic against the array model.
        for (int n = 0; n < 120; n++) begin
            int op, a, s, len;
            op = int'($urandom_range(3));
            a = int'($urandom_range(BS - 1));
            s = int'($urandom_range(1));
            case (op)
                0: host_op(1'b1, a, s, 8'($urandom), rd);
                1: begin
                    host_op(1'b0, a, s, 8'h00, rd);
                    check("rnd_host_rdata", 32'(rd), 32'(model_mem[a][s*8 +: 8]));
                end
                default: begin
                    len = int'($urandom_range(6));
                    for (int i = 0; i < len; i++) bdata[i] = 16'($urandom);
                    burst(op == 2, a, len, int'($urandom));
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unified_buffer_burst.md
# unified_buffer_burst

Parametrised next-generation on-chip unified buffer sitting between the host FIFO bridge and the systolic compute array. A single-port word memory is shared by two clients. The host port does byte-lane (section) reads and writes. The compute port does full-word, multi-lane burst transfers with a start/length command. An internal state machine arbitrates between the two clients, sequences bursts and signals completion.

## Interface
Parameters:
- BUFFER_SIZE, 1024, words in the buffer.
- COMPUTE_DATA_WIDTH, 4, bits per compute lane.
- ARRAY_SIZE, 4, compute lanes per word.
- FIFO_DATA_WIDTH, 8, bits per host section.
- BUFFER_WORD_SIZE, ARRAY_SIZE*COMPUTE_DATA_WIDTH, derived word width; must be a multiple of FIFO_DATA_WIDTH.
- SECTIONS, BUFFER_WORD_SIZE/FIFO_DATA_WIDTH, derived host sections per word.
- ADDRESS_SIZE, $clog2(BUFFER_SIZE), derived.
- SECTION_BITS, max(1,$clog2(SECTIONS)), derived.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk in 1: clock, rising edge.
  - rst in 1: reset.
- Host port:
  - host_valid in 1: host request.
  - host_ready out 1: host request accepted this cycle.
  - host_we in 1: 1 = write, 0 = read.
  - host_address in ADDRESS_SIZE: word address.
  - host_section in SECTION_BITS: lane select; section s = bits [FIFO_DATA_WIDTH*(s+1)-1 : FIFO_DATA_WIDTH*s].
  - host_wdata in FIFO_DATA_WIDTH: write data.
  - host_rdata out FIFO_DATA_WIDTH: read data.
  - host_rvalid out 1: host_rdata valid.
- Compute port:
  - cmp_start in 1: burst command.
  - cmp_we in 1: 1 = write burst, 0 = read burst.
  - cmp_base in ADDRESS_SIZE: first word address.
  - cmp_len in ADDRESS_SIZE+1: number of words in the burst.
  - cmp_busy out 1: burst in progress.
  - compute_in in COMPUTE_DATA_WIDTH x [ARRAY_SIZE]: write lanes.
  - compute_in_valid in 1: write beat present.
  - compute_out out COMPUTE_DATA_WIDTH x [ARRAY_SIZE]: read lanes.
  - compute_out_valid out 1: read beat valid.
  - done out 1: one-cycle pulse at burst completion.
  - error out 1: one-cycle pulse when a burst is rejected.

## Operation
- Word lane mapping: lane i occupies bits [COMPUTE_DATA_WIDTH*(i+1)-1 : COMPUTE_DATA_WIDTH*i].
- States:
  - IDLE: accepts commands.
  - WR_BURST: accepts write beats.
  - RD_BURST: issues reads.
  - RD_DRAIN: outputs the last read word.
- IDLE:
  - A cmp_start is accepted and has priority over host_valid in the same cycle; host_ready = host_valid && !cmp_start.
  - Accepted host write updates only the selected section; the other sections are untouched.
  - Accepted host read returns the selected section on host_rdata with host_rvalid the next cycle.
  - cmp_start loads ptr = cmp_base and rem = cmp_len. It goes to WR_BURST if cmp_we is set, otherwise RD_BURST.
  - cmp_len = 0 does no memory access, stays in IDLE and pulses done next cycle.
- WR_BURST:
  - Each cycle with compute_in_valid writes all lanes to mem[ptr], then ptr++ and rem--.
  - Cycles without compute_in_valid stall with no write.
  - After the beat that makes rem = 0: return to IDLE and pulse done the next cycle.
- RD_BURST: each cycle reads mem[ptr], then ptr++ and rem--. When rem reaches 0, go to RD_DRAIN.
- RD_DRAIN: goes to IDLE. done coincides with the last compute_out_valid.
- cmp_busy is high in WR_BURST, RD_BURST and RD_DRAIN. host_ready is 0 and cmp_start is ignored while cmp_busy is high.
- Address pointer wraps modulo BUFFER_SIZE, except when UB_BOUNDS_CHECK_EN is defined (see Configuration).

## Timing
- Reset values:
  - host_ready, host_rvalid, cmp_busy, compute_out_valid, done, error: 0.
  - host_rdata, compute_out: 0.
  - State: IDLE.
  - Memory contents are not reset.
- Reset mid-burst: returns to IDLE immediately. Words already written stay written. No done pulse.
- Latencies:
  - Host read: 1 cycle, accept to host_rvalid.
  - Host write: visible to any read issued the next cycle.
  - Read burst: first compute_out_valid 1 cycle after the first RD_BURST cycle. N beats arrive on consecutive cycles with no gaps and no backpressure.
  - Write burst: peak throughput 1 word/cycle.
- Back-to-back: a new cmp_start is accepted in the cycle after done is pulsed.

## Configuration
- UB_BOUNDS_CHECK_EN defined:
  - cmp_start with cmp_base + cmp_len > BUFFER_SIZE is rejected.
  - On rejection: error pulses the next cycle, state stays IDLE, no access and no done.
- UB_BOUNDS_CHECK_EN undefined: no check; error is tied to 0 and the burst address wraps to 0 after BUFFER_SIZE-1.

## Test plan
All cases use defaults unless noted (16-bit word, SECTIONS=2).
- Host section write: write section 1 = 0xAB at addr 5, then section 0 = 0xCD. A full-word read burst (base 5, len 1) then returns compute_out = {0xA,0xB,0xC,0xD} (lane3 to lane0), with done on the same cycle.
- Write burst with stalls: base 10, len 3, beats 0x1111/0x2222/0x3333 with one compute_in_valid gap. Result: mem[10..12] written, done exactly 1 cycle after the third beat, cmp_busy low in that cycle.
- Read burst: base 10, len 3. Result: compute_out_valid on 3 consecutive cycles starting 2 cycles after cmp_start, data in order, done on the third beat.
- Arbitration: cmp_start and host_valid in the same IDLE cycle. The host is stalled (host_ready=0) until done, then accepted the next cycle. A cmp_start with len=0 gives a done pulse and no memory change.
- Boundary: BUFFER_SIZE=16, base 14, len 4.
  - Without the macro: writes land at 14, 15, 0, 1.
  - With UB_BOUNDS_CHECK_EN: error pulse, memory unchanged, no done.
- Reset mid read burst: assert rst after 2 of 5 beats. All outputs drop to 0 asynchronously, no further beats, and the next host read works normally.
